// File: rtl/spi_master_tx_pkg.sv
// Shared definitions for the pixel-link SPI transmitter and its clock divider.
package spi_master_tx_pkg;

  localparam int DEFAULT_WORD_WIDTH  = 16;
  localparam int DEFAULT_CLK_DIV     = 2;
  localparam int DEFAULT_RESET_PULSE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } tx_state_t;

  // Counter width that stays at least one bit for a modulus of 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_master_tx_if.sv
// Word handshake between the frame-source logic (master) and the SPI transmitter (slave).
interface spi_master_tx_if
  import spi_master_tx_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
);

  logic [WORD_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/spi_clk_divider.sv
// Half-period counter: while run is high, phase_end strobes every CLK_DIV clocks.
module spi_clk_divider
  import spi_master_tx_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic phase_end
);

  localparam int DW = cnt_width(CLK_DIV);

  logic [DW-1:0] div_cnt_reg;

  assign phase_end = run && (div_cnt_reg == DW'(CLK_DIV - 1));

  // Counter restarts from zero whenever the phase ends or the link is idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt_reg <= '0;
    end else if (!run || phase_end) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_tx.sv
// SPI transmitter for the 16-bit pixel link: MSB first, edge-counted framing, no chip select.
// Optional slave reset pulse (link_reset/resync) is enabled by defining SPI_TX_LINK_RESET_EN.
module spi_master_tx
  import spi_master_tx_pkg::*;
#(
  parameter int CLK_DIV     = DEFAULT_CLK_DIV,
  parameter int WORD_WIDTH  = DEFAULT_WORD_WIDTH,
  parameter int RESET_PULSE = DEFAULT_RESET_PULSE
) (
  input  logic           clock,
  input  logic           reset,
  spi_master_tx_if.slave tx,
  output logic           spi_clk,
  output logic           spi_mosi,
  output logic           busy,
  output logic           word_done,
  input  logic           resync,
  output logic           link_reset
);

  localparam int BW = cnt_width(WORD_WIDTH);

  tx_state_t             state_reg, state_next;
  logic [WORD_WIDTH-1:0] shift_reg, shift_next;
  logic [BW-1:0]         bit_cnt_reg, bit_cnt_next;
  logic                  spi_clk_reg, spi_clk_next;
  logic                  busy_reg, busy_next;
  logic                  word_done_reg, word_done_next;
  logic                  armed_reg;
  logic                  hold_ready;
  logic                  phase_end;
  logic                  last_bit;
  logic                  accept;

  spi_clk_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clock     (clock),
    .reset     (reset),
    .run       (state_reg != IDLE),
    .phase_end (phase_end)
  );

  assign last_bit = (bit_cnt_reg == BW'(WORD_WIDTH - 1));

  // Ready in IDLE and in the final HIGH cycle of a word, so a stream has no gap.
  assign tx.in_ready = armed_reg && !hold_ready &&
                       ((state_reg == IDLE) ||
                        ((state_reg == HIGH) && phase_end && last_bit));
  assign accept = tx.in_ready && tx.in_valid;

  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    bit_cnt_next   = bit_cnt_reg;
    word_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          shift_next   = tx.in_data;
          bit_cnt_next = '0;
          state_next   = LOW;
        end
      end
      LOW: begin
        if (phase_end) state_next = HIGH;
      end
      HIGH: begin
        if (phase_end) begin
          if (!last_bit) begin
            shift_next   = {shift_reg[WORD_WIDTH-2:0], 1'b0};
            bit_cnt_next = bit_cnt_reg + 1'b1;
            state_next   = LOW;
          end else begin
            word_done_next = 1'b1;
            if (accept) begin
              shift_next   = tx.in_data;
              bit_cnt_next = '0;
              state_next   = LOW;
            end else begin
              state_next = IDLE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
    spi_clk_next = (state_next == HIGH);
    busy_next    = (state_next != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      spi_clk_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      word_done_reg <= 1'b0;
      armed_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      bit_cnt_reg   <= bit_cnt_next;
      spi_clk_reg   <= spi_clk_next;
      busy_reg      <= busy_next;
      word_done_reg <= word_done_next;
      armed_reg     <= 1'b1;
    end
  end

  // MOSI is the shift register MSB, so it only moves on LOW entry and holds between words.
  assign spi_clk   = spi_clk_reg;
  assign spi_mosi  = shift_reg[WORD_WIDTH-1];
  assign busy      = busy_reg;
  assign word_done = word_done_reg;

`ifdef SPI_TX_LINK_RESET_EN
  localparam int PW = cnt_width(RESET_PULSE);

  logic          link_reset_reg;
  logic          resync_d_reg;
  logic          pending_reg;
  logic [PW-1:0] pulse_cnt_reg;
  logic          pulse_start;

  // A resync edge is parked until the word in flight has finished.
  assign pulse_start = pending_reg && !link_reset_reg && (state_reg == IDLE);
  assign hold_ready  = link_reset_reg || pending_reg;
  assign link_reset  = link_reset_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      link_reset_reg <= 1'b1;
      resync_d_reg   <= 1'b0;
      pending_reg    <= 1'b0;
      pulse_cnt_reg  <= '0;
    end else begin
      resync_d_reg <= resync;
      pending_reg  <= (pending_reg || (resync && !resync_d_reg)) && !pulse_start;
      if (pulse_start) begin
        link_reset_reg <= 1'b1;
        pulse_cnt_reg  <= '0;
      end else if (link_reset_reg) begin
        if (pulse_cnt_reg == PW'(RESET_PULSE - 1)) begin
          link_reset_reg <= 1'b0;
          pulse_cnt_reg  <= '0;
        end else begin
          pulse_cnt_reg <= pulse_cnt_reg + 1'b1;
        end
      end
    end
  end
`else
  logic unused_link_cfg;

  assign hold_ready      = 1'b0;
  assign link_reset      = 1'b0;
  assign unused_link_cfg = resync ^ RESET_PULSE[0];
`endif

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx with a bit-level model of the edge-counting SPI slave.
module tb_spi_master_tx;

  localparam int CLK_DIV = 2;
  localparam int WW      = 16;

  logic clock;
  logic reset;
  logic spi_clk, spi_mosi, busy, word_done, resync, link_reset;

  spi_master_tx_if #(.WORD_WIDTH(WW)) tx_if ();

  spi_master_tx #(.CLK_DIV(CLK_DIV), .WORD_WIDTH(WW), .RESET_PULSE(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .tx         (tx_if),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .busy       (busy),
    .word_done  (word_done),
    .resync     (resync),
    .link_reset (link_reset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Slave model and link monitor, sampled on the falling edge.
  int          cyc = 0, edges = 0, done_cnt = 0, busy_cyc = 0, busy_falls = 0;
  int          ready_busy = 0, gap_bad = 0, mosi_viol = 0, last_edge_cyc = 0;
  int          sl_cnt = 0;
  logic        sclk_prev = 1'b0, mosi_prev = 1'b0, busy_prev = 1'b0, have_word = 1'b0;
  logic [15:0] sl_shift = '0, sl_word = '0;
  logic [15:0] rx_q[$];
  logic [15:0] pub_q[$];

  always @(negedge clock) begin
    if (!reset) begin
      sl_cnt    = 0;
      sclk_prev = 1'b0;
      mosi_prev = 1'b0;
      busy_prev = 1'b0;
    end else begin
      cyc++;
      if (spi_clk && (spi_mosi !== mosi_prev)) mosi_viol++;
      if (spi_clk && !sclk_prev) begin
        edges++;
        if (sl_cnt != 0 && (cyc - last_edge_cyc) != 2 * CLK_DIV) gap_bad++;
        if (sl_cnt == 0 && have_word) pub_q.push_back(sl_word);
        sl_shift = {sl_shift[14:0], spi_mosi};
        sl_cnt++;
        if (sl_cnt == WW) begin
          sl_cnt    = 0;
          sl_word   = sl_shift;
          have_word = 1'b1;
          rx_q.push_back(sl_shift);
        end
        last_edge_cyc = cyc;
      end
      if (word_done) done_cnt++;
      if (busy) busy_cyc++;
      if (busy_prev && !busy) busy_falls++;
      if (busy && tx_if.in_ready) ready_busy++;
      sclk_prev = spi_clk;
      mosi_prev = spi_mosi;
      busy_prev = busy;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w);
    int n = 0;
    tx_if.in_data  = w;
    tx_if.in_valid = 1'b1;
    while (tx_if.in_ready !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
    chk("ready_wait", 32'(n < 500), 32'd1);
    tick();
    tx_if.in_valid = 1'b0;
    tx_if.in_data  = ~w;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (word_done !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    chk({nm, "_done_wait"}, 32'(n < 2000), 32'd1);
  endtask

  typedef struct {
    logic [15:0] data;
    logic [15:0] exp_word;
    logic        exp_last_mosi;
  } vec_t;

  vec_t        vecs[6];
  logic [15:0] b2b[3];
  logic [15:0] lb[3];
  logic        hold_bit;
  int          e0, d0, bc0, bf0, rb0, bad, n;

  initial begin
    vecs[0] = '{16'hA5C3, 16'hA5C3, 1'b1};
    vecs[1] = '{16'h0001, 16'h0001, 1'b1};
    vecs[2] = '{16'h8000, 16'h8000, 1'b0};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1};
    vecs[4] = '{16'h0000, 16'h0000, 1'b0};
    vecs[5] = '{16'h1234, 16'h1234, 1'b0};
    b2b[0] = 16'h0001; b2b[1] = 16'h8000; b2b[2] = 16'hFFFF;
    lb[0]  = 16'h1234; lb[1]  = 16'hBEEF; lb[2]  = 16'h0000;

    reset          = 1'b0;
    resync         = 1'b0;
    tx_if.in_valid = 1'b0;
    tx_if.in_data  = '0;
    repeat (3) tick();
    chk("rst_spi_clk", 32'(spi_clk), 32'd0);
    chk("rst_spi_mosi", 32'(spi_mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_word_done", 32'(word_done), 32'd0);
    chk("rst_in_ready", 32'(tx_if.in_ready), 32'd0);
    reset = 1'b1;
`ifdef SPI_TX_LINK_RESET_EN
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("lr_after_rst_%0d", i), 32'(link_reset), 32'(i < 4));
      if (i < 4) chk($sformatf("lr_ready_%0d", i), 32'(tx_if.in_ready), 32'd0);
    end
`else
    tick();
    chk("link_reset_tied", 32'(link_reset), 32'd0);
`endif
    repeat (2) tick();

    // Isolated words with idle gaps.
    for (int i = 0; i < 6; i++) begin
      e0 = edges;
      d0 = done_cnt;
      send_word(vecs[i].data);
      wait_done($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_busy_fall", i), 32'(busy), 32'd0);
      tick();
      chk($sformatf("vec%0d_word", i), 32'(rx_q[$]), 32'(vecs[i].exp_word));
      chk($sformatf("vec%0d_edges", i), 32'(edges - e0), 32'd16);
      chk($sformatf("vec%0d_done_pulses", i), 32'(done_cnt - d0), 32'd1);
      chk($sformatf("vec%0d_idle_mosi", i), 32'(spi_mosi), 32'(vecs[i].exp_last_mosi));
      chk($sformatf("vec%0d_idle_sclk", i), 32'(spi_clk), 32'd0);
    end
    chk("edge_spacing", 32'(gap_bad), 32'd0);

    // Back-to-back stream with in_valid held.
    e0 = edges; d0 = done_cnt; bc0 = busy_cyc; bf0 = busy_falls; rb0 = ready_busy;
    tx_if.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_if.in_data = b2b[i];
      n = 0;
      while (tx_if.in_ready !== 1'b1 && n < 500) begin
        tick();
        n++;
      end
      chk($sformatf("b2b_ready%0d", i), 32'(n < 500), 32'd1);
      tick();
    end
    tx_if.in_valid = 1'b0;
    n = 0;
    while ((done_cnt - d0) < 3 && n < 1000) begin
      tick();
      n++;
    end
    repeat (2) tick();
    chk("b2b_edges", 32'(edges - e0), 32'd48);
    chk("b2b_busy_cycles", 32'(busy_cyc - bc0), 32'd192);
    chk("b2b_busy_falls", 32'(busy_falls - bf0), 32'd1);
    chk("b2b_ready_in_busy", 32'(ready_busy - rb0), 32'd3);
    chk("b2b_done", 32'(done_cnt - d0), 32'd3);
    chk("b2b_w0", 32'(rx_q[rx_q.size()-3]), 32'h0001);
    chk("b2b_w1", 32'(rx_q[rx_q.size()-2]), 32'h8000);
    chk("b2b_w2", 32'(rx_q[rx_q.size()-1]), 32'hFFFF);

    // Loopback through the slave model: word N appears on word N+1's first edge.
    pub_q.delete();
    for (int i = 0; i < 3; i++) begin
      send_word(lb[i]);
      wait_done($sformatf("lb%0d", i));
      tick();
    end
    chk("lb_publishes", 32'(pub_q.size()), 32'd3);
    chk("lb_pub_1234", 32'(pub_q[1]), 32'h1234);
    chk("lb_pub_beef", 32'(pub_q[2]), 32'hBEEF);

    // Stall of 37 cycles between words.
    send_word(16'h6B2D);
    wait_done("stall_a");
    hold_bit = spi_mosi;
    chk("stall_last_bit", 32'(hold_bit), 32'd1);
    bad = 0;
    for (int i = 0; i < 37; i++) begin
      tick();
      if (spi_clk !== 1'b0 || spi_mosi !== hold_bit) bad++;
    end
    chk("stall_hold", 32'(bad), 32'd0);
    send_word(16'h9E71);
    wait_done("stall_b");
    tick();
    chk("stall_next_word", 32'(rx_q[$]), 32'h9E71);

    // Reset after five edges of a word.
    e0 = edges;
    tx_if.in_data = 16'hFC01;
    send_word(16'hFC01);
    n = 0;
    while ((edges - e0) < 5 && n < 500) begin
      tick();
      n++;
    end
    chk("mid_edges", 32'(edges - e0), 32'd5);
    reset = 1'b0;
    #1;
    chk("mid_rst_sclk", 32'(spi_clk), 32'd0);
    chk("mid_rst_mosi", 32'(spi_mosi), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(tx_if.in_ready), 32'd0);
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    send_word(16'h5AA5);
    wait_done("after_rst");
    tick();
    chk("after_rst_word", 32'(rx_q[$]), 32'h5AA5);

`ifdef SPI_TX_LINK_RESET_EN
    // resync mid-word: the pulse waits for the word to finish.
    send_word(16'h1357);
    repeat (10) tick();
    resync = 1'b1;
    tick();
    resync = 1'b0;
    bad = 0;
    n = 0;
    while (word_done !== 1'b1 && n < 500) begin
      if (link_reset !== 1'b0) bad++;
      tick();
      n++;
    end
    chk("resync_deferred", 32'(bad), 32'd0);
    chk("resync_done_seen", 32'(n < 500), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("resync_pulse_%0d", i), 32'(link_reset), 32'(i <= 4));
      if (i <= 4) chk($sformatf("resync_ready_%0d", i), 32'(tx_if.in_ready), 32'd0);
    end
`endif

    chk("mosi_stable_high", 32'(mosi_viol), 32'd0);
    chk("edge_spacing_all", 32'(gap_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
- Transmit end of the 16-bit pixel-data SPI link into the HUB75 controller's SPI slave.
- Accepts words from the frame-source logic over a valid/ready handshake and serialises them MSB first on spi_mosi/spi_clk.
- Word framing is by clock count only; there is no chip select. The block always emits exactly WORD_WIDTH spi_clk rising edges per word and never a partial word.
- Runs in the system clock domain; spi_clk is a divided, registered output.

Parameters:
- CLK_DIV, 2, system clocks per spi_clk half-period; legal values are 1 or greater.
- WORD_WIDTH, 16, bits per word; must equal the slave word size.
- RESET_PULSE, 4, system clocks of link_reset pulse (optional feature only).

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low; asserted when 0.
- in_data  in  WORD_WIDTH  word to send; bit WORD_WIDTH-1 is sent first.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  a word is accepted in a cycle where in_valid and in_ready are both 1.
- spi_clk  out  1  serial clock; idles low; the slave samples on its rising edge.
- spi_mosi  out  1  serial data; changes only while spi_clk is low.
- busy  out  1  a word is in flight.
- word_done  out  1  one-cycle pulse after the last rising edge of each word.
- resync  in  1  request a link_reset pulse (optional feature only).
- link_reset  out  1  active-high reset to the slave (optional feature only).

Behaviour:
- Reset values: spi_clk=0, spi_mosi=0, busy=0, word_done=0, in_ready=0 while reset is asserted; state=IDLE; counters=0. All outputs are registered except in_ready.
- States:
  - IDLE: in_ready=1. On accept, load the shift register with in_data, drive spi_mosi=in_data[MSB] in the next cycle, set bit_cnt=0, and go to LOW.
  - LOW: spi_clk=0 for CLK_DIV cycles, then go to HIGH.
  - HIGH: spi_clk=1 for CLK_DIV cycles. On expiry:
    - If bit_cnt < WORD_WIDTH-1: shift left, spi_mosi=next bit, bit_cnt++, go to LOW.
    - Otherwise: pulse word_done and end the word (back-to-back rule below).
- Back-to-back: in_ready is also 1 in the final cycle of HIGH on the last bit. If in_valid is 1 there, load the new word and go straight to LOW with no gap. A sustained stream therefore takes exactly 2*CLK_DIV*WORD_WIDTH clocks per word.
- Data setup: spi_mosi is stable for the full LOW phase before each rising edge and held through HIGH.
- in_ready is 0 in every other cycle. in_data is ignored while in_ready=0, and the loaded word is unaffected by later changes on in_data.
- Gaps between words: spi_clk holds low and spi_mosi holds its last bit. Idle gaps of any length are legal because the slave counts edges only.
- Slave latency note: the slave publishes word N on the first rising edge of word N+1. Upstream sends a trailing pad word when the final word must be visible.
- Reset mid-word: the output returns to idle at once, and the slave bit counter is then misaligned. Realignment needs the slave reset (optional feature) or a system-level reset of both ends.
- Division: div_cnt counts 0..CLK_DIV-1. With CLK_DIV=1, spi_clk toggles every clock.

Optional Feature:
- Macro: SPI_TX_LINK_RESET_EN.
- Defined:
  - link_reset drives high for RESET_PULSE clocks after reset deasserts, and on each resync rising edge when IDLE.
  - A resync seen while busy is held pending until IDLE.
  - in_ready=0 while link_reset=1.
- Undefined: the resync input is unused, link_reset is tied 0, and there is no extra logic.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE/LOW/HIGH;
  - default WORD_WIDTH=16, matching the slave;
  - CLK_DIV default.
- One natural sub-module, spi_clk_divider: half-period counter producing a phase_end strobe. It is reused by the later readback receiver.

Test Plan:
- Single word: CLK_DIV=2, send 16'hA5C3 -> 16 rising edges 4 clocks apart; sampled bits give A5C3 MSB first; word_done pulses once; busy then falls.
- Back-to-back: three words 16'h0001, 16'h8000, 16'hFFFF with in_valid held -> 48 contiguous edges and no idle cycle; in_ready high only in IDLE/last-HIGH cycles; 192 clocks total.
- Loopback with the slave model: send words 16'h1234, 16'hBEEF, 16'h0000 -> slave data reads 1234 after the first edge of word 2, and BEEF after the first edge of word 3.
- Stall: in_valid drops for 37 cycles between words -> spi_clk stays low, spi_mosi holds, and the next word is still correct.
- Reset mid-word: assert reset after 5 edges -> spi_clk=0, spi_mosi=0, busy=0 immediately; after release the next word transmits all 16 bits.
- SPI_TX_LINK_RESET_EN: after reset release, link_reset is high for 4 clocks and in_ready=0 meanwhile; resync pulsed mid-word -> pulse starts only after word_done.
